swervolf_wb_arb2: RTL
=====================

# swervolf_wb_arb2

Two-master Wishbone arbiter that shares one classic-cycle slave port, typically the system controller register window, between the CPU data bus (master 0) and a debug/host master (master 1). It grants the slave with round-robin priority, holds each grant for the whole `cyc` assertion so multi-access sequences stay atomic, and inserts one idle cycle between owners. An optional bus watchdog terminates hung accesses with an error.

## Interface
- `AW`, 32: address width, identical on both master ports and the slave port.
- `TIMEOUT_CYCLES`, 16'd255: watchdog limit in cycles, legal range 2..65535. Used only with `SWERVOLF_WB_ARB2_TIMEOUT_EN`.

Ports, listed as name, direction, width, meaning:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_m0_adr`, in, AW; `i_m0_dat`, in, 32; `i_m0_sel`, in, 4; `i_m0_we`, `i_m0_cyc`, `i_m0_stb`, in, 1: master 0 request.
- `o_m0_rdt`, out, 32; `o_m0_ack`, `o_m0_err`, out, 1: master 0 response.
- `i_m1_*` and `o_m1_*`: same set for master 1.
- `o_s_adr`, out, AW; `o_s_dat`, out, 32; `o_s_sel`, out, 4; `o_s_we`, `o_s_cyc`, `o_s_stb`, out, 1: slave request.
- `i_s_rdt`, in, 32; `i_s_ack`, `i_s_err`, in, 1: slave response.
- `o_grant`, out, 2: one-hot current owner (bit 0 = m0); 0 when idle or aborting.

## Operation
- State machine: `IDLE`, `GNT0`, `GNT1`, `ABORT`.
- Registered state: `last` (last owner, 1 bit).
- Transitions from `IDLE`:
  - Only m0 has `cyc` high → `GNT0`.
  - Only m1 has `cyc` high → `GNT1`.
  - Both have `cyc` high → the master other than `last` is granted.
  - On entering `GNTx`, `last` is set to x.
- `GNTx` → `IDLE` when `i_mx_cyc` is low.
- Slave request signals are muxed from the owner. In `IDLE`/`ABORT` the mux selects m0 fields.
- `o_s_cyc = i_mx_cyc` and `o_s_stb = i_mx_stb`, both gated by `GNTx`. Both are 0 in `IDLE`/`ABORT`.
- Responses:
  - `o_m0_rdt` and `o_m1_rdt` always equal `i_s_rdt`.
  - `o_mx_ack = i_s_ack & GNTx`.
  - `o_mx_err = i_s_err & GNTx`, OR the watchdog error.
  - The non-owner never sees ack or err.
- Slave responses arriving in `IDLE`/`ABORT` are dropped.

## Timing
- Reset values:
  - State `IDLE`, `last`=1, so m0 wins the first contention.
  - Watchdog count 0.
  - All outputs low: `o_grant`=0, `o_s_cyc`=0, `o_s_stb`=0, all acks and errs 0.
- `i_rst` is sampled at the clock edge. Outputs are in reset state from the following cycle, including mid-transaction. An in-flight access is abandoned with no ack.
- Arbitration latency:
  - `cyc` rises in cycle N while `IDLE` → `o_s_cyc`/`o_grant` high in N+1.
  - Slave ack reaches the master in the same cycle (combinational).
- Owner drops `cyc` in cycle M → `o_s_cyc` low in M, state `IDLE` in M+1.
- A waiting master is granted in M+2. The slave therefore sees at least one cycle with `cyc` low between owners.
- Grant is never preempted while the owner holds `cyc`. Round-robin guarantees m1 service after at most one m0 tenure.

## Configuration
- Macro `SWERVOLF_WB_ARB2_TIMEOUT_EN`.
- Defined, 16-bit watchdog:
  - The count clears whenever the state is not `GNTx`, `o_s_stb`=0, or `i_s_ack|i_s_err`. Otherwise it increments.
  - When count == `TIMEOUT_CYCLES`, `o_mx_err` pulses for exactly one cycle and the state moves to `ABORT`; the pulse cycle already has `o_s_cyc`=0.
  - `ABORT` → `IDLE` once the aborted master drops `cyc`.
  - A genuine `i_s_ack` in the same cycle as the limit wins: no error, no abort.
- Undefined: no counter, `ABORT` unreachable, errors are only `i_s_err` pass-through. `TIMEOUT_CYCLES` is ignored.

## Test plan
- m0 single write, adr 0x10, dat 0xA5A5_0001, slave acks 1 cycle after stb → `o_s_cyc` one cycle after `cyc`, `o_m0_ack` 1 cycle, `o_grant`=01, m1 sees no ack.
- Both raise `cyc` in the same cycle after reset → m0 granted first; after m0 drops `cyc`, one idle cycle, then m1 granted (`o_grant`=10); repeat, m0 next.
- m0 holds `cyc` for 3 back-to-back accesses while m1 requests → m1 granted only after the 3rd ack plus m0 `cyc` low plus one idle cycle.
- `i_rst` pulsed while m1 owns with `stb` high → next cycle `o_s_cyc`=0, `o_grant`=0; first contention after reset goes to m0.
- `TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, slave never acks → single `o_m0_err` pulse 8 cycles after stb, `o_s_cyc` low in that cycle; m1 granted after m0 drops `cyc`.
- `TIMEOUT_EN`, ack arrives exactly at count 8 → ack delivered, no err, no abort. Without the macro, same stimulus hangs with no err.

Source files
------------

// File: rtl/swervolf_wb_arb2.sv
// Two-master Wishbone classic-cycle arbiter for a shared slave port.
// Master 0 is the CPU data bus, master 1 the debug/host master. Arbitration is
// round-robin, a grant is held for the owner's whole cyc assertion, and one
// idle cycle separates successive owners.
// Optional bus watchdog: define SWERVOLF_WB_ARB2_TIMEOUT_EN to enable it.
module swervolf_wb_arb2 #(
    parameter int          AW             = 32,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    output logic [31:0]   o_m0_rdt,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    input  logic [AW-1:0] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    output logic [31:0]   o_m1_rdt,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [AW-1:0] o_s_adr,
    output logic [31:0]   o_s_dat,
    output logic [3:0]    o_s_sel,
    output logic          o_s_we,
    output logic          o_s_cyc,
    output logic          o_s_stb,
    input  logic [31:0]   i_s_rdt,
    input  logic          i_s_ack,
    input  logic          i_s_err,
    output logic [1:0]    o_grant
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

    state_t state_q;
    logic   last_q;     // last owner; the other master wins a tie
    logic   gnt0;
    logic   gnt1;
    logic   own_cyc;
    logic   own_stb;
    logic   tmo_hit;    // watchdog limit reached while the owner still strobes
    logic   tmo_err;    // limit reached and the slave did not respond this cycle

    assign gnt0    = (state_q == GNT0);
    assign gnt1    = (state_q == GNT1);
    assign o_grant = {gnt1, gnt0};

    // Request mux defaults to master 0 whenever master 1 is not the owner.
    assign own_cyc = gnt1 ? i_m1_cyc : i_m0_cyc;
    assign own_stb = gnt1 ? i_m1_stb : i_m0_stb;
    assign o_s_adr = gnt1 ? i_m1_adr : i_m0_adr;
    assign o_s_dat = gnt1 ? i_m1_dat : i_m0_dat;
    assign o_s_sel = gnt1 ? i_m1_sel : i_m0_sel;
    assign o_s_we  = gnt1 ? i_m1_we  : i_m0_we;

    // The timeout cycle already withdraws cyc/stb from the slave.
    assign o_s_cyc = (gnt0 | gnt1) & own_cyc & ~tmo_hit;
    assign o_s_stb = (gnt0 | gnt1) & own_stb & ~tmo_hit;

    // Responses go only to the owner; anything arriving in IDLE/ABORT is dropped.
    assign o_m0_rdt = i_s_rdt;
    assign o_m1_rdt = i_s_rdt;
    assign o_m0_ack = i_s_ack & gnt0;
    assign o_m1_ack = i_s_ack & gnt1;
    assign o_m0_err = gnt0 & (i_s_err | tmo_err);
    assign o_m1_err = gnt1 & (i_s_err | tmo_err);

`ifdef SWERVOLF_WB_ARB2_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tmo_hit = (gnt0 | gnt1) & own_cyc & own_stb & (cnt_q == TIMEOUT_CYCLES);
    // A real slave response in the limit cycle wins over the watchdog.
    assign tmo_err = tmo_hit & ~i_s_ack & ~i_s_err;
    assign cnt_d   = (!(gnt0 | gnt1) || !o_s_stb || i_s_ack || i_s_err) ? 16'd0
                                                                         : cnt_q + 16'd1;

    // Stall counter: counts cycles the owner strobes without a slave response.
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= 16'd0;
        else       cnt_q <= cnt_d;
    end
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
    assign tmo_err        = 1'b0;
`endif

    // Ownership FSM: round-robin grant, held until the owner drops cyc.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_m0_cyc && i_m1_cyc) begin
                        state_q <= last_q ? GNT0 : GNT1;
                        last_q  <= ~last_q;
                    end else if (i_m0_cyc) begin
                        state_q <= GNT0;
                        last_q  <= 1'b0;
                    end else if (i_m1_cyc) begin
                        state_q <= GNT1;
                        last_q  <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!i_m0_cyc)    state_q <= IDLE;
                    else if (tmo_err) state_q <= ABORT;
                end
                GNT1: begin
                    if (!i_m1_cyc)    state_q <= IDLE;
                    else if (tmo_err) state_q <= ABORT;
                end
                ABORT: begin
                    // last_q still names the aborted master.
                    if (!(last_q ? i_m1_cyc : i_m0_cyc)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
